// File: rtl/suspend_arbiter.sv
// Round-robin owner of the core's single hold resource. Each window freezes the core for a latched per-requester length and records the PC.
// Optional: define SUSPEND_ARB_STATS_EN to add a saturating 16-bit hold_total cycle counter.
module suspend_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int CNT_W   = 5,
    parameter int PC_W    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] req_len,
    input  logic [PC_W-1:0]          pm_addr,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     hold,
    output logic                     start_hold,
    output logic                     end_hold,
    output logic [CNT_W-1:0]         hold_count,
    output logic [PC_W-1:0]          saved_pc
`ifdef SUSPEND_ARB_STATS_EN
    ,
    output logic [15:0]              hold_total
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_END
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   hold_count_q, hold_count_d;
    logic [PC_W-1:0]    saved_pc_q, saved_pc_d;
    logic               hold_q, hold_d;
    logic               start_hold_q, start_hold_d;
    logic               end_hold_q, end_hold_d;

    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic [CNT_W-1:0]   pick_len;
    int unsigned        cand;

    // Search starts at ptr_q and wraps, so the last winner is visited last.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr_q) + i) % NUM_REQ;
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(cand);
            end
        end
        pick_len = req_len[int'(pick_idx)*CNT_W +: CNT_W];
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        win_d        = win_q;
        ptr_d        = ptr_q;
        len_d        = len_q;
        hold_count_d = hold_count_q;
        saved_pc_d   = saved_pc_q;
        hold_d       = 1'b0;
        start_hold_d = 1'b0;
        end_hold_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d      = ST_HOLD;
                    grant_d      = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    win_d        = pick_idx;
                    len_d        = (pick_len == '0) ? CNT_W'(1) : pick_len;
                    saved_pc_d   = pm_addr;
                    hold_count_d = '0;
                    hold_d       = 1'b1;
                    start_hold_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (hold_count_q == len_q - CNT_W'(1)) begin
                    state_d      = ST_END;
                    hold_count_d = '0;
                    end_hold_d   = 1'b1;
                end else begin
                    hold_count_d = hold_count_q + CNT_W'(1);
                    hold_d       = 1'b1;
                end
            end
            ST_END: begin
                state_d = ST_IDLE;
                grant_d = '0;
                ptr_d   = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            win_q        <= '0;
            ptr_q        <= '0;
            len_q        <= '0;
            hold_count_q <= '0;
            saved_pc_q   <= '0;
            hold_q       <= 1'b0;
            start_hold_q <= 1'b0;
            end_hold_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            win_q        <= win_d;
            ptr_q        <= ptr_d;
            len_q        <= len_d;
            hold_count_q <= hold_count_d;
            saved_pc_q   <= saved_pc_d;
            hold_q       <= hold_d;
            start_hold_q <= start_hold_d;
            end_hold_q   <= end_hold_d;
        end
    end

    assign grant      = grant_q;
    assign hold       = hold_q;
    assign start_hold = start_hold_q;
    assign end_hold   = end_hold_q;
    assign hold_count = hold_count_q;
    assign saved_pc   = saved_pc_q;

`ifdef SUSPEND_ARB_STATS_EN
    logic [15:0] hold_total_q, hold_total_d;

    always_comb begin
        hold_total_d = hold_total_q;
        if (hold_q && hold_total_q != 16'hFFFF) begin
            hold_total_d = hold_total_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_total_q <= '0;
        end else begin
            hold_total_q <= hold_total_d;
        end
    end

    assign hold_total = hold_total_q;
`endif

endmodule
